// File: rtl/qsys_avm_pkg.sv
// Shared types and helpers for the Avalon-MM command master: FSM state encoding
// and the layout of a packed command word {write, address, data}.
package qsys_avm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_RDWAIT = 2'd2
  } state_e;

  localparam int AVM_ADDR_W = 2;
  localparam int AVM_DATA_W = 32;

  // Data occupies the low bits, address sits above it, the write flag is the MSB.
  function automatic int cmd_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  function automatic int cmd_addr_lsb(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/qsys_avm_cmd_master_if.sv
// Bundle of the local command/response stream and the Avalon-MM initiator bus.
// cmd: a command moves on a rising edge where cmd_valid && cmd_ready; cmd_valid and its
// fields must hold until then; rsp_valid is a one-cycle pulse with no backpressure.
interface qsys_avm_cmd_master_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic              avm_read_n;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_data, avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_data, busy,
           avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_data, avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_data, busy,
           avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
  );
endinterface

// File: rtl/qsys_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; a push is refused when full
// even if a pop happens on the same edge.
module qsys_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/qsys_avm_cmd_master.sv
// Avalon-MM initiator: queues local write/read commands and runs each as one
// registered bus transfer, returning read data as a one-cycle response pulse.
module qsys_avm_cmd_master
  import qsys_avm_pkg::*;
#(
  parameter int ADDR_W       = AVM_ADDR_W,
  parameter int DATA_W       = AVM_DATA_W,
  parameter int CMD_DEPTH    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  qsys_avm_cmd_master_if.master bus,
  output state_e                dbg_state_o
);
  localparam int          CMD_W    = cmd_w(ADDR_W, DATA_W);
  localparam int          ADDR_LSB = cmd_addr_lsb(DATA_W);
  localparam int          CNT_W    = $clog2(CMD_DEPTH) + 1;
  localparam logic [1:0]  LAT_INIT = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  state_e            state_q, state_d;
  logic              cs_q, cs_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        lat_q, lat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [CMD_W-1:0]  head;
  logic              fifo_full, fifo_empty, pop, release_bus;
  logic [CNT_W-1:0]  fifo_count;

  qsys_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (bus.cmd_valid),
    .wdata_i ({bus.cmd_write, bus.cmd_address, bus.cmd_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    wr_n_d      = wr_n_q;
    rd_n_d      = rd_n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
    release_bus = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!bus.avm_waitrequest) begin
          if (!rd_n_q && READ_LATENCY != 0) begin
            release_bus = 1'b1;
            lat_d       = LAT_INIT;
            state_d     = ST_RDWAIT;
          end else begin
            if (!rd_n_q) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = bus.avm_readdata;
            end
            // Chain straight into the next queued command so the bus never idles.
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              release_bus = 1'b1;
              state_d     = ST_IDLE;
            end
          end
        end
      end
      ST_RDWAIT: begin
        if (lat_q == 2'd0) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.avm_readdata;
          state_d     = ST_IDLE;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      cs_d    = 1'b1;
      wr_n_d  = ~head[CMD_W-1];
      rd_n_d  = head[CMD_W-1];
      addr_d  = head[ADDR_LSB +: ADDR_W];
      wdata_d = head[DATA_W-1:0];
    end
    if (release_bus) begin
      cs_d    = 1'b0;
      wr_n_d  = 1'b1;
      rd_n_d  = 1'b1;
      addr_d  = '0;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cs_q        <= 1'b0;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.cmd_ready      = !fifo_full;
  assign bus.busy           = (fifo_count != '0) || (state_q != ST_IDLE);
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write_n    = wr_n_q;
  assign bus.avm_read_n     = rd_n_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = wdata_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_qsys_avm_cmd_master.sv
// Directed bench for qsys_avm_cmd_master against a 4-register PIO slave model
// with one clock of read latency and a bench-controlled waitrequest.
module tb_qsys_avm_cmd_master;
  import qsys_avm_pkg::*;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  state_e dbg_state;
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     rsp_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] regs [4];
  logic        wr_pend = 1'b0, rd_pend = 1'b0;
  logic [1:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_val = '0;

  qsys_avm_cmd_master_if #(.ADDR_W(2), .DATA_W(32)) bus ();

  qsys_avm_cmd_master #(.ADDR_W(2), .DATA_W(32), .CMD_DEPTH(4), .READ_LATENCY(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave model: sample the bus mid-cycle, commit writes / launch reads on the edge.
  always begin
    @(negedge clk);
    #2;
    wr_pend = 1'b0;
    rd_pend = 1'b0;
    if (reset_n && bus.avm_chipselect && !bus.avm_waitrequest) begin
      if (!bus.avm_write_n) begin
        wr_data_q.push_back(bus.avm_writedata);
        wr_cyc_q.push_back(cyc);
        wr_pend = 1'b1;
        wr_addr = bus.avm_address;
        wr_val  = bus.avm_writedata;
      end
      if (!bus.avm_read_n) begin
        rd_pend = 1'b1;
        rd_addr = bus.avm_address;
      end
    end
    if (bus.rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
      else check("rsp_data", bus.rsp_data, exp_q.pop_front());
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (wr_pend) regs[wr_addr] = wr_val;
    if (rd_pend) bus.avm_readdata = regs[rd_addr];
  end

  task automatic send_cmd(input logic w, input logic [1:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = w;
    bus.cmd_address = a;
    bus.cmd_data    = d;
    n = 0;
    while (!bus.cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n == 64) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) regs[i] = '0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0; bus.cmd_data = '0;
    bus.avm_readdata = '0; bus.avm_waitrequest = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs", bus.avm_chipselect, 1'b0);
    check("rst_write_n", bus.avm_write_n, 1'b1);
    check("rst_read_n", bus.avm_read_n, 1'b1);
    check("rst_addr", bus.avm_address, 2'd0);
    check("rst_wdata", bus.avm_writedata, 32'd0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.cmd_ready, 1'b1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;

    // 1: single zero-wait write, latency and one-cycle strobe
    send_cmd(1'b1, 2'd0, 32'h12345678);
    @(negedge clk);
    check("t1_cs_latency", bus.avm_chipselect, 1'b0);
    check("t1_busy_queued", bus.busy, 1'b1);
    @(negedge clk);
    check("t1_cs", bus.avm_chipselect, 1'b1);
    check("t1_write_n", bus.avm_write_n, 1'b0);
    check("t1_read_n", bus.avm_read_n, 1'b1);
    check("t1_addr", bus.avm_address, 2'd0);
    check("t1_wdata", bus.avm_writedata, 32'h12345678);
    @(negedge clk);
    check("t1_cs_idle", bus.avm_chipselect, 1'b0);
    check("t1_busy_done", bus.busy, 1'b0);
    check("t1_nwrites", 32'(wr_data_q.size()), 32'd1);

    // 2: same write stalled by waitrequest for three cycles
    wr_data_q.delete(); wr_cyc_q.delete();
    bus.avm_waitrequest = 1'b1;
    send_cmd(1'b1, 2'd0, 32'h12345678);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_cs_hold", bus.avm_chipselect, 1'b1);
      check("t2_write_n_hold", bus.avm_write_n, 1'b0);
      check("t2_addr_hold", bus.avm_address, 2'd0);
      check("t2_wdata_hold", bus.avm_writedata, 32'h12345678);
      if (i == 3) bus.avm_waitrequest = 1'b0;
    end
    @(negedge clk);
    check("t2_cs_idle", bus.avm_chipselect, 1'b0);
    check("t2_nwrites", 32'(wr_data_q.size()), 32'd1);

    // 3: fill the queue behind a stalled write, then drain back-to-back
    wr_data_q.delete(); wr_cyc_q.delete();
    bus.avm_waitrequest = 1'b1;
    for (int i = 1; i <= 5; i++) send_cmd(1'b1, 2'd0, 32'(i));
    @(negedge clk);
    check("t3_full_ready", bus.cmd_ready, 1'b0);
    check("t3_inflight", bus.avm_writedata, 32'h1);
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    check("t3_ready_after_first", bus.cmd_ready, 1'b1);
    repeat (8) @(negedge clk);
    check("t3_nwrites", 32'(wr_data_q.size()), 32'd5);
    if (wr_data_q.size() == 5) begin
      for (int i = 0; i < 5; i++) check("t3_order", wr_data_q[i], 32'(i + 1));
      for (int i = 1; i < 5; i++) check("t3_gap", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd1);
    end

    // 4: write then two reads through the PIO model
    wr_data_q.delete(); wr_cyc_q.delete();
    rsp_cnt = 0;
    exp_q.push_back(32'hA5A50F0F);
    exp_q.push_back(32'h00000000);
    send_cmd(1'b1, 2'd0, 32'hA5A50F0F);
    send_cmd(1'b0, 2'd0, 32'h0);
    send_cmd(1'b0, 2'd1, 32'h0);
    repeat (15) @(negedge clk);
    check("t4_nrsp", 32'(rsp_cnt), 32'd2);
    check("t4_exp_left", 32'(exp_q.size()), 32'd0);
    check("t4_rsp_hold", bus.rsp_data, 32'h0);
    check("t4_busy", bus.busy, 1'b0);

    // 5: asynchronous reset in the middle of a stalled write with two queued
    wr_data_q.delete(); wr_cyc_q.delete();
    rsp_cnt = 0;
    bus.avm_waitrequest = 1'b1;
    send_cmd(1'b1, 2'd0, 32'h51);
    send_cmd(1'b1, 2'd0, 32'h52);
    send_cmd(1'b1, 2'd0, 32'h53);
    @(negedge clk);
    check("t5_cs_before", bus.avm_chipselect, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("t5_cs_async", bus.avm_chipselect, 1'b0);
    check("t5_write_n_async", bus.avm_write_n, 1'b1);
    check("t5_busy_async", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    bus.avm_waitrequest = 1'b0;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_busy", bus.busy, 1'b0);
    check("t5_ready", bus.cmd_ready, 1'b1);
    check("t5_cs", bus.avm_chipselect, 1'b0);
    check("t5_nwrites", 32'(wr_data_q.size()), 32'd0);
    check("t5_nrsp", 32'(rsp_cnt), 32'd0);

    // 6: simultaneous push/pop at 3 entries, then a push refused at full
    wr_data_q.delete(); wr_cyc_q.delete();
    bus.avm_waitrequest = 1'b1;
    for (int i = 1; i <= 4; i++) send_cmd(1'b1, 2'd2, 32'h60 + 32'(i));
    @(negedge clk);
    check("t6_three_ready", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_address = 2'd2; bus.cmd_data = 32'h65;
    bus.avm_waitrequest = 1'b0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    check("t6_simul_ready", bus.cmd_ready, 1'b1);
    send_cmd(1'b1, 2'd2, 32'h66);
    @(negedge clk);
    check("t6_full", bus.cmd_ready, 1'b0);
    bus.cmd_valid = 1'b1; bus.cmd_data = 32'h67;
    bus.avm_waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_refused_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_nwrites", 32'(wr_data_q.size()), 32'd7);
    if (wr_data_q.size() == 7) begin
      for (int i = 0; i < 7; i++) check("t6_order", wr_data_q[i], 32'h61 + 32'(i));
    end
    check("t6_busy", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
